// File: rtl/dips_pkg.sv
// Shared defaults and the event record for the DIP switch debouncer.
// The record pairs the new debounced levels with the mask of bits that toggled.
package dips_pkg;
  localparam int DIP_WIDTH_DEF       = 8;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int FIFO_DEPTH_DEF      = 4;

  typedef struct packed {
    logic [DIP_WIDTH_DEF-1:0] state;
    logic [DIP_WIDTH_DEF-1:0] changed;
  } dip_ev_t;
endpackage

// File: rtl/dips_event_fifo.sv
// Event FIFO, any packed type: a write is visible at rd_vld one edge later, never same-cycle.
// Under backpressure the head holds; a write into a full FIFO without a same-cycle read is dropped and pulses drop.
module dips_event_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [15:0]
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic wr_vld,
  input  T     wr_dat,
  input  logic rd_rdy,
  output logic rd_vld,
  output T     rd_dat,
  output logic drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wr_ptr, rd_ptr;
  T            mem [DEPTH];
  logic        empty, full, do_rd, do_wr;

  // The extra MSB on each pointer separates full from empty when the indices match.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd  = rd_rdy && !empty;
  assign do_wr  = wr_vld && (!full || do_rd);
  assign drop   = wr_vld && full && !do_rd;
  assign rd_vld = !empty;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge ACLK) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

  always_comb begin
    rd_dat = '0;
    if (!empty) rd_dat = mem[rd_ptr[AW-1:0]];
  end
endmodule

// File: rtl/dips_debounce.sv
// DIP switch debouncer: stable_state follows a steady dip_in level 2+DEBOUNCE_CYCLES edges after it is first sampled.
// Each update is queued as one event; ev_valid/ev_ready handshake, events arriving at a full FIFO are dropped and flag overflow.
module dips_debounce
  import dips_pkg::*;
#(
  parameter int DIP_WIDTH       = DIP_WIDTH_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int FIFO_DEPTH      = FIFO_DEPTH_DEF
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic [DIP_WIDTH-1:0] dip_in,
  output logic [DIP_WIDTH-1:0] stable_state,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [DIP_WIDTH-1:0] ev_state,
  output logic [DIP_WIDTH-1:0] ev_changed,
  output logic                 overflow,
  input  logic                 ovf_clr
);
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = 1;

  // Same layout as dip_ev_t, sized to this instance's DIP_WIDTH.
  typedef struct packed {
    logic [DIP_WIDTH-1:0] state;
    logic [DIP_WIDTH-1:0] changed;
  } ev_t;

  logic [DIP_WIDTH-1:0] sync1, sync2, diff, tog;
  logic [CW-1:0]        cnt [DIP_WIDTH];
  ev_t                  push_ev, head_ev;
  logic                 push, drop;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= dip_in;
      sync2 <= sync1;
    end
  end

  assign diff = sync2 ^ stable_state;

  always_comb begin
    tog = '0;
    for (int i = 0; i < DIP_WIDTH; i++) begin
      tog[i] = diff[i] && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      stable_state <= '0;
      for (int i = 0; i < DIP_WIDTH; i++) cnt[i] <= '0;
    end else begin
      stable_state <= stable_state ^ tog;
      for (int i = 0; i < DIP_WIDTH; i++) begin
        cnt[i] <= (diff[i] && !tog[i]) ? cnt[i] + CNT_ONE : '0;
      end
    end
  end

  // The event carries the post-toggle levels so it matches stable_state after this edge.
  assign push = |tog;
  always_comb begin
    push_ev.state   = stable_state ^ tog;
    push_ev.changed = tog;
  end

  dips_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (ev_t)
  ) u_fifo (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .wr_vld  (push),
    .wr_dat  (push_ev),
    .rd_rdy  (ev_ready),
    .rd_vld  (ev_valid),
    .rd_dat  (head_ev),
    .drop    (drop)
  );

  assign ev_state   = head_ev.state;
  assign ev_changed = head_ev.changed;

  // A drop in the same cycle as ovf_clr wins so no overflow is ever lost.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) overflow <= 1'b0;
    else          overflow <= drop | (overflow & ~ovf_clr);
  end
endmodule

// File: tb/tb_dips_debounce.sv
// Bench for dips_debounce: directed scenarios plus random switching against a window-based reference model.
module tb_dips_debounce;
  import dips_pkg::*;

  localparam int W     = 8;
  localparam int D     = 16;
  localparam int DEPTH = 4;

  logic         ACLK     = 1'b0;
  logic         ARESETN  = 1'b0;
  logic [W-1:0] dip_in   = '0;
  logic         ev_ready = 1'b0;
  logic         ovf_clr  = 1'b0;
  logic [W-1:0] stable_state, ev_state, ev_changed;
  logic         ev_valid, overflow;

  int errors = 0;
  int checks = 0;

  // Reference model: a bit flips once its last D synchronized samples all differ from its stable level.
  logic [W-1:0] m_pipe[$];
  logic [W-1:0] m_win[$];
  logic [W-1:0] m_stable;
  dip_ev_t      m_q[$];
  logic         m_ovf;

  always #5 ACLK = ~ACLK;

  dips_debounce #(
    .DIP_WIDTH       (W),
    .DEBOUNCE_CYCLES (D),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .dip_in       (dip_in),
    .stable_state (stable_state),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_state     (ev_state),
    .ev_changed   (ev_changed),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr)
  );

  task automatic model_reset();
    m_pipe.delete();
    m_pipe.push_back('0);
    m_pipe.push_back('0);
    m_win.delete();
    m_q.delete();
    m_stable = '0;
    m_ovf    = 1'b0;
  endtask

  // Advance the model over the coming edge using the current inputs, then let the DUT take that edge.
  task automatic tick();
    logic [W-1:0] seen, mask;
    logic         pop, drop;
    dip_ev_t      e;
    pop  = ev_ready && (m_q.size() > 0);
    seen = m_pipe.pop_front();
    m_pipe.push_back(dip_in);
    m_win.push_back(seen);
    if (m_win.size() > D) void'(m_win.pop_front());
    mask = (m_win.size() == D) ? {W{1'b1}} : {W{1'b0}};
    foreach (m_win[j]) mask &= (m_win[j] ^ m_stable);
    m_stable ^= mask;
    if (pop) void'(m_q.pop_front());
    drop = 1'b0;
    if (mask != '0) begin
      if (m_q.size() < DEPTH) begin
        e.state   = m_stable;
        e.changed = mask;
        m_q.push_back(e);
      end else begin
        drop = 1'b1;
      end
    end
    m_ovf = drop | (m_ovf & ~ovf_clr);
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARESETN = 1'b0; dip_in = '0; ev_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    checks++; if (stable_state !== 8'h00) begin errors++; $display("FAIL reset_stable: got %h want 00", stable_state); end
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_ev_valid: got %b want 0", ev_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if ({ev_state, ev_changed} !== 16'h0000) begin errors++; $display("FAIL reset_ev_data: got %h/%h want 00/00", ev_state, ev_changed); end
    ARESETN = 1'b1;
    model_reset();
    tick();
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got ev_valid %b want 0", ev_valid); end
  endtask

  task automatic test_glitch();
    dip_in = 8'h08;
    repeat (10) tick();
    dip_in = 8'h00;
    for (int c = 0; c < 25; c++) begin
      tick();
      checks++; if (stable_state !== 8'h00) begin errors++; $display("FAIL glitch_stable: cycle %0d got %h want 00", c, stable_state); end
      checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL glitch_no_event: cycle %0d got ev_valid %b want 0", c, ev_valid); end
    end
  endtask

  task automatic test_basic();
    dip_in = 8'h05;
    repeat (17) tick();
    checks++; if (stable_state !== 8'h00) begin errors++; $display("FAIL basic_early: got %h want 00 after 17 edges", stable_state); end
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", ev_valid); end
    tick();
    checks++; if (stable_state !== 8'h05) begin errors++; $display("FAIL basic_latency: got %h want 05 after 18 edges", stable_state); end
    checks++; if (stable_state !== m_stable) begin errors++; $display("FAIL basic_model: got %h want %h", stable_state, m_stable); end
    checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL basic_ev_valid: got %b want 1", ev_valid); end
    checks++; if ({ev_state, ev_changed} !== 16'h0505) begin errors++; $display("FAIL basic_event: got %h/%h want 05/05", ev_state, ev_changed); end
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL basic_single_event: got ev_valid %b want 0", ev_valid); end
    checks++; if ({ev_state, ev_changed} !== 16'h0000) begin errors++; $display("FAIL basic_empty_data: got %h/%h want 00/00", ev_state, ev_changed); end
  endtask

  task automatic test_overflow();
    int           bits  [5] = '{4, 5, 6, 7, 0};
    logic [W-1:0] exp_s [4] = '{8'h15, 8'h35, 8'h75, 8'hF5};
    logic [W-1:0] exp_c [4] = '{8'h10, 8'h20, 8'h40, 8'h80};
    ev_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      dip_in = dip_in ^ (8'd1 << bits[k]);
      repeat (20) tick();
      checks++; if ({ev_state, ev_changed} !== 16'h1510) begin errors++; $display("FAIL ovf_head_hold: event %0d got %h/%h want 15/10", k, ev_state, ev_changed); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL ovf_flag: event %0d got %b want %b", k, overflow, m_ovf); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL ovf_drain_valid: slot %0d got %b want 1", i, ev_valid); end
      checks++; if ({ev_state, ev_changed} !== {exp_s[i], exp_c[i]}) begin errors++; $display("FAIL ovf_drain_order: slot %0d got %h/%h want %h/%h", i, ev_state, ev_changed, exp_s[i], exp_c[i]); end
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
    end
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL ovf_fifth_dropped: got ev_valid %b want 0", ev_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_full_pop();
    int n;
    ev_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dip_in = dip_in ^ (8'd1 << k);
      repeat (20) tick();
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pre_ovf: got %b want 0", overflow); end
    dip_in = dip_in ^ 8'h10;
    repeat (17) tick();
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    checks++; if (stable_state !== 8'hEB) begin errors++; $display("FAIL full_stable: got %h want EB", stable_state); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pop_no_ovf: got %b want 0", overflow); end
    checks++; if (ev_state !== 8'hF7) begin errors++; $display("FAIL full_pop_head: got %h want F7", ev_state); end
    n = 0;
    for (int i = 0; i < 8 && ev_valid; i++) begin
      checks++; if (m_q.size() == 0) begin errors++; $display("FAIL full_drain_extra: got ev_valid 1 want 0"); end
      else if ({ev_state, ev_changed} !== {m_q[0].state, m_q[0].changed}) begin
        errors++; $display("FAIL full_drain_data: got %h/%h want %h/%h", ev_state, ev_changed, m_q[0].state, m_q[0].changed);
      end
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
      n++;
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL full_occupancy: got %0d events want 4", n); end
  endtask

  task automatic test_reset_mid();
    ev_ready = 1'b0;
    for (int k = 4; k < 7; k++) begin
      dip_in = dip_in ^ (8'd1 << k);
      repeat (20) tick();
    end
    checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_queued: got ev_valid %b want 1", ev_valid); end
    ARESETN = 1'b0;
    #2;
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", ev_valid); end
    checks++; if (stable_state !== 8'h00) begin errors++; $display("FAIL rst_mid_stable: got %h want 00", stable_state); end
    dip_in = 8'hFF;
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    model_reset();
    repeat (17) tick();
    checks++; if (stable_state !== 8'h00) begin errors++; $display("FAIL rst_init_early: got %h want 00", stable_state); end
    tick();
    checks++; if (stable_state !== 8'hFF) begin errors++; $display("FAIL rst_init_latency: got %h want FF", stable_state); end
    checks++; if ({ev_valid, ev_state, ev_changed} !== {1'b1, 16'hFFFF}) begin errors++; $display("FAIL rst_init_event: got v=%b %h/%h want v=1 FF/FF", ev_valid, ev_state, ev_changed); end
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rst_single_event: got ev_valid %b want 0", ev_valid); end
  endtask

  task automatic test_random();
    logic         exp_vld;
    logic [W-1:0] exp_s, exp_c;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 99) < 4) dip_in = dip_in ^ (8'd1 << $urandom_range(0, 7));
      ev_ready = ($urandom_range(0, 3) == 0);
      ovf_clr  = ($urandom_range(0, 49) == 0);
      tick();
      exp_vld = (m_q.size() > 0);
      exp_s   = exp_vld ? m_q[0].state   : '0;
      exp_c   = exp_vld ? m_q[0].changed : '0;
      checks++; if (stable_state !== m_stable) begin errors++; $display("FAIL rand_stable: cycle %0d got %h want %h", c, stable_state, m_stable); end
      checks++; if (ev_valid !== exp_vld) begin errors++; $display("FAIL rand_valid: cycle %0d got %b want %b", c, ev_valid, exp_vld); end
      checks++; if ({ev_state, ev_changed} !== {exp_s, exp_c}) begin errors++; $display("FAIL rand_event: cycle %0d got %h/%h want %h/%h", c, ev_state, ev_changed, exp_s, exp_c); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow: cycle %0d got %b want %b", c, overflow, m_ovf); end
    end
    ev_ready = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_basic();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dips_debounce.md
DIPS_DEBOUNCE -- requirements
Module: dips_debounce

Interface
REQ-001 Parameter DIP_WIDTH, default 8: number of DIP switch lines.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: consecutive cycles a new level must persist before it is accepted; legal range 2..65535.
REQ-003 Parameter FIFO_DEPTH, default 4: event FIFO depth; power of two, at least 2.
REQ-004 Port ACLK, input, 1: single clock; all state is on the rising edge.
REQ-005 Port ARESETN, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port dip_in, input, DIP_WIDTH: raw asynchronous switch levels.
REQ-007 Port stable_state, output, DIP_WIDTH: debounced switch levels.
REQ-008 Port ev_valid, output, 1: event available at the FIFO head.
REQ-009 Port ev_ready, input, 1: downstream AXI register stage accepts the event.
REQ-010 Port ev_state, output, DIP_WIDTH: stable_state captured with the event.
REQ-011 Port ev_changed, output, DIP_WIDTH: mask of the bits that toggled in the event.
REQ-012 Port overflow, output, 1: sticky flag, set when an event is dropped.
REQ-013 Port ovf_clr, input, 1: single-cycle clear for overflow.

Function
REQ-014 Each dip_in bit shall pass through a two-flop synchronizer before any other logic uses it.
REQ-015 Each bit shall have a counter that increments while the synchronized bit differs from stable_state, and returns to 0 in any cycle where the two are equal.
REQ-016 When a bit's counter reaches DEBOUNCE_CYCLES-1 and the bit still differs, stable_state for that bit shall toggle on that edge and the counter shall clear.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles shall produce no change in stable_state.
REQ-018 End-to-end latency from the first edge that samples a new, steady dip_in level to the stable_state update shall be exactly 2+DEBOUNCE_CYCLES edges.
REQ-019 All bits that toggle on the same edge shall form a single event: ev_state is the new stable_state and ev_changed is the toggle mask.
REQ-020 An event shall be pushed into the FIFO on the edge where stable_state updates, and ev_valid shall be high in the following cycle.
REQ-021 Handshake: an event transfers when ev_valid and ev_ready are both high. ev_state and ev_changed shall hold steady while ev_valid is high and ev_ready is low.
REQ-022 When the FIFO is full and a push occurs without a pop in the same cycle, the event shall be dropped, FIFO contents are unchanged, and overflow is set.
REQ-023 When the FIFO is full and a push and a pop occur in the same cycle, the push shall be accepted; no overflow.
REQ-024 When the FIFO is empty, ev_valid shall be 0, and a push cannot bypass to the outputs in the same cycle.
REQ-025 FIFO read and write pointers shall wrap modulo FIFO_DEPTH; full and empty shall be distinguished by an extra pointer bit.
REQ-026 If ovf_clr and a new overflow occur in the same cycle, overflow shall remain 1.
REQ-027 Events shall be delivered in push order.

Reset
REQ-028 While ARESETN is low, the following shall be 0: synchronizer flops, counters, stable_state, FIFO pointers, ev_valid, overflow.
REQ-029 While the FIFO is empty, ev_state and ev_changed shall read 0.
REQ-030 Reset asserted mid-operation shall discard all queued events and any partially debounced level.
REQ-031 After reset deasserts, a dip_in bit held at 1 shall generate an initial-state event after the REQ-018 latency.

Structure
REQ-032 A shared package dips_pkg shall hold the DIP_WIDTH default, the DEBOUNCE_CYCLES default, and the typedef for the event record (state plus changed mask).
REQ-033 The FIFO shall be a separate sub-module, dips_event_fifo, parameterised on depth and on the event type.
REQ-034 Counter width shall be derived from DEBOUNCE_CYCLES with $clog2.

Verification (DIP_WIDTH=8, DEBOUNCE_CYCLES=16, FIFO_DEPTH=4)
REQ-035 Release reset, then drive dip_in 0x00 to 0x05 and hold -> stable_state=0x05 exactly 18 edges later; one event {state 0x05, changed 0x05}; ev_valid high on the next cycle.
REQ-036 Pulse dip_in bit 3 high for 10 cycles -> stable_state stays 0x00; no event.
REQ-037 Hold ev_ready=0 and generate 5 events -> first 4 retained, 5th dropped, overflow=1; then drain -> 4 events in order; pulse ovf_clr -> overflow=0.
REQ-038 FIFO full, ev_ready=1 on the same edge as a new event -> event accepted, overflow stays 0, occupancy stays 4.
REQ-039 Assert ARESETN low with 3 events queued -> ev_valid=0 and stable_state=0x00 immediately; after release with dip_in=0xFF -> single event {0xFF, 0xFF} after 18 edges.
